// File: rtl/m_result_uart.sv
// rtl/m_result_uart.sv - sends captured result/cycle count as a 19-char ASCII line over 8N1 UART
//
// Purpose: on a rising edge of the processor halt flag (while idle), latch the
// result word and cycle count and transmit "RRRRRRRR CCCCCCCC\r\n" in lowercase hex.
//
// Ports:
//   w_clk   in   system clock
//   w_rst   in   synchronous active-high reset
//   w_halt  in   processor halt flag (level)
//   w_rout  in   [31:0] processor result word
//   w_cnt   in   [31:0] cycle counter value
//   r_txd   out  UART serial data, idle high
//   r_busy  out  high while a message is being sent
//   r_done  out  one-cycle pulse after the last stop bit

module m_result_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_halt,
    input  logic [31:0] w_rout,
    input  logic [31:0] w_cnt,
    output logic        r_txd,
    output logic        r_busy,
    output logic        r_done
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  LAST_CHAR = 5'd18;

    state_t      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [4:0]  char_idx_q, char_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [31:0] res_q, res_d;
    logic [31:0] cnt_q, cnt_d;
    logic        halt_prev_q, halt_prev_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [2:0]  nib_sel;
    logic [3:0]  nib;
    logic [7:0]  hex_char;
    logic [7:0]  cur_char;
    logic        bit_end;

    // Character generator: maps the current char index to its ASCII code.
    always_comb begin
        nib_sel  = 3'd0;
        nib      = 4'h0;
        if (char_idx_q < 5'd8) begin
            nib_sel = char_idx_q[2:0];
            nib     = res_q[5'd31 - {nib_sel, 2'b00} -: 4];
        end else begin
            nib_sel = 3'(char_idx_q - 5'd9);
            nib     = cnt_q[5'd31 - {nib_sel, 2'b00} -: 4];
        end
        hex_char = (nib < 4'd10) ? {4'h3, nib} : (8'h57 + {4'h0, nib});

        if (char_idx_q < 5'd8)       cur_char = hex_char;
        else if (char_idx_q == 5'd8) cur_char = 8'h20;
        else if (char_idx_q <= 5'd16) cur_char = hex_char;
        else if (char_idx_q == 5'd17) cur_char = 8'h0d;
        else                          cur_char = 8'h0a;
    end

    assign bit_end = (bit_cnt_q == LAST_CLK);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        char_idx_d  = char_idx_q;
        bit_idx_d   = bit_idx_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        txd_d       = txd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        halt_prev_d = w_halt;

        case (state_q)
            S_IDLE: begin
                if (w_halt && !halt_prev_q) begin
                    res_d      = w_rout;
                    cnt_d      = w_cnt;
                    busy_d     = 1'b1;
                    txd_d      = 1'b0;
                    bit_cnt_d  = 16'd0;
                    char_idx_d = 5'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = 16'd0;
                    bit_idx_d = 3'd0;
                    txd_d     = cur_char[0];
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = cur_char[bit_idx_q + 3'd1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = 16'd0;
                    if (char_idx_q < LAST_CHAR) begin
                        // Next character starts immediately, no idle gap.
                        char_idx_d = char_idx_q + 5'd1;
                        txd_d      = 1'b0;
                        state_d    = S_START;
                    end else begin
                        char_idx_d = 5'd0;
                        busy_d     = 1'b0;
                        txd_d      = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 16'd0;
            char_idx_q  <= 5'd0;
            bit_idx_q   <= 3'd0;
            res_q       <= 32'd0;
            cnt_q       <= 32'd0;
            halt_prev_q <= 1'b1;   // a halt already high at release is not an edge
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            char_idx_q  <= char_idx_d;
            bit_idx_q   <= bit_idx_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            halt_prev_q <= halt_prev_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign r_txd  = txd_q;
    assign r_busy = busy_q;
    assign r_done = done_q;

endmodule

// File: tb/tb_m_result_uart.sv
// tb/tb_m_result_uart.sv - scoreboard bench for m_result_uart (CLKS_PER_BIT 4 and 2)

module tb_m_result_uart;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        halt [2];
    logic [31:0] rout [2];
    logic [31:0] cnt  [2];
    logic        txd  [2];
    logic        busy [2];
    logic        done [2];

    m_result_uart #(.CLKS_PER_BIT(4)) u_dut4 (
        .w_clk(clk), .w_rst(rst), .w_halt(halt[0]), .w_rout(rout[0]), .w_cnt(cnt[0]),
        .r_txd(txd[0]), .r_busy(busy[0]), .r_done(done[0])
    );

    m_result_uart #(.CLKS_PER_BIT(2)) u_dut2 (
        .w_clk(clk), .w_rst(rst), .w_halt(halt[1]), .w_rout(rout[1]), .w_cnt(cnt[1]),
        .r_txd(txd[1]), .r_busy(busy[1]), .r_done(done[1])
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int abort_cnt [2] = '{0, 0};

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Serial decoder + scoreboard for one DUT instance.
    task automatic monitor(input int k, input int clks);
        logic [7:0] b;
        logic       stop_bit;
        int         ab;
        forever begin
            @(negedge clk);
            if (txd[k] !== 1'b0) continue;
            ab = abort_cnt[k];
            repeat (clks / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (clks) @(negedge clk);
                b[j] = txd[k];
            end
            repeat (clks) @(negedge clk);
            stop_bit = txd[k];
            if (ab != abort_cnt[k]) continue;   // frame cut by reset
            check($sformatf("stop bit inst%0d", k), stop_bit, 1);
            if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL unexpected byte inst%0d actual=%02h required=none", k, b);
            end else if (k == 0) begin
                check("rx byte inst0", b, exp0.pop_front());
            end else begin
                check("rx byte inst1", b, exp1.pop_front());
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 2);

    task automatic push_msg(input int k, input logic [31:0] r, input logic [31:0] c);
        string s;
        s = {$sformatf("%08h %08h", r, c), "\r\n"};
        for (int i = 0; i < s.len(); i++) begin
            if (k == 0) exp0.push_back(s[i]);
            else        exp1.push_back(s[i]);
        end
    endtask

    task automatic run_msg(input int k, input int clks, input logic [31:0] r,
                           input logic [31:0] c, input int pulse_at, input bit clobber);
        int n;
        int busy_n;
        bit got;
        halt[k] = 1'b0;
        repeat (2) @(negedge clk);
        rout[k] = r;
        cnt[k]  = c;
        push_msg(k, r, c);
        halt[k] = 1'b1;
        @(negedge clk);
        check("txd low after trigger", txd[k], 0);
        check("busy after trigger", busy[k], 1);
        if (clobber) begin
            rout[k] = 32'hffffffff;
            cnt[k]  = 32'h12345678;
        end
        n = 0;
        busy_n = int'(busy[k]);
        got = 1'b0;
        while (n < 190 * clks + 50) begin
            @(negedge clk);
            n++;
            if (pulse_at > 0 && n == pulse_at)     halt[k] = 1'b0;
            if (pulse_at > 0 && n == pulse_at + 2) halt[k] = 1'b1;
            if (done[k]) begin
                got = 1'b1;
                break;
            end
            busy_n += int'(busy[k]);
        end
        check("done latency", got ? n : -1, 190 * clks);
        check("busy cycles", busy_n, 190 * clks);
        check("busy low at done", busy[k], 0);
        check("txd idle at done", txd[k], 1);
        @(negedge clk);
        check("done single cycle", done[k], 0);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            halt[k] = 1'b1;
            rout[k] = 32'h0;
            cnt[k]  = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset txd", txd[k], 1);
            check("reset busy", busy[k], 0);
            check("reset done", done[k], 0);
        end
        rst = 1'b0;

        // Halt high through reset release must not send anything.
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (busy[k] || !txd[k]) bad++;
        end
        check("no send on held halt at release", bad, 0);
        halt[0] = 1'b0;
        halt[1] = 1'b0;

        // Basic message with input change right after capture.
        run_msg(0, 4, 32'h05ffa000, 32'h0000012c, 0, 1'b1);

        // Held halt: no further message.
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (busy[0] || !txd[0]) bad++;
        end
        check("held halt single message", bad, 0);

        // Halt re-pulse during a message is ignored; after done it starts a new one.
        run_msg(0, 4, $urandom, $urandom, 300, 1'b0);
        run_msg(0, 4, $urandom, $urandom, 0, 1'b0);

        // Reset in the middle of a message.
        halt[0] = 1'b0;
        repeat (2) @(negedge clk);
        rout[0] = $urandom;
        cnt[0]  = $urandom;
        push_msg(0, rout[0], cnt[0]);
        halt[0] = 1'b1;
        repeat (100) @(negedge clk);
        abort_cnt[0]++;
        exp0.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("txd after mid reset", txd[0], 1);
        check("busy after mid reset", busy[0], 0);
        bad = 0;
        repeat (800) begin
            @(negedge clk);
            if (done[0] || busy[0]) bad++;
        end
        check("no done after mid reset", bad, 0);
        run_msg(0, 4, $urandom, $urandom, 0, 1'b0);

        for (int i = 0; i < 2; i++) run_msg(0, 4, $urandom, $urandom, 0, 1'b0);

        // Minimum-ish bit period instance.
        run_msg(1, 2, 32'h00000000, 32'hdeadbeef, 0, 1'b0);
        run_msg(1, 2, $urandom, $urandom, 0, 1'b0);

        repeat (20) @(negedge clk);
        check("scoreboard inst0 drained", exp0.size(), 0);
        check("scoreboard inst1 drained", exp1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_result_uart.md
Name: m_result_uart

Overview:
- Downstream consumer of the processor's result outputs (r_rout, r_halt) and the top-level cycle counter.
- When the processor halts, it captures the final result word and the cycle count once.
- It sends both as a fixed 19-character ASCII line over a single-wire 8N1 UART transmitter, for board bring-up without the 7-segment display.
- It sits in the board top beside the 7-segment controller.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (434 = 50 MHz / 115200); legal range 2..65535.

Ports:
- w_clk    input   1   system clock
- w_rst    input   1   synchronous, active-high reset
- w_halt   input   1   processor halt flag (level; stays high once set)
- w_rout   input   32  processor result word
- w_cnt    input   32  cycle counter value
- r_txd    output  1   UART serial data, idle high
- r_busy   output  1   high while a message is being sent
- r_done   output  1   one-cycle pulse after the last stop bit of a message

Behaviour:
- Clock and reset:
  - One clock, w_clk.
  - w_rst is synchronous and active-high, sampled on the posedge of w_clk.
  - All state is in registers updated on the posedge of w_clk.
- Reset values:
  - r_txd=1, r_busy=0, r_done=0.
  - FSM=IDLE, bit counter=0, char index=0, captured words=0.
  - Halt-history register=1, so a halt that is already high at reset release does not trigger a send.
- Trigger:
  - Fires in IDLE on an edge where w_halt==1 and the halt-history register==0 (rising edge).
  - On that edge, capture w_rout into the result register and w_cnt into the count register, set r_busy=1, and enter START for char 0.
  - r_txd goes 0 on that same edge.
  - The halt-history register samples w_halt every cycle, in every state.
- Message, 19 chars, char index 0..18:
  - Chars 0-7: result, 8 lowercase hex digits, MSB nibble first ('0'-'9' = 8'h30-8'h39, 'a'-'f' = 8'h61-8'h66).
  - Char 8: 8'h20 (space).
  - Chars 9-16: count, 8 lowercase hex digits, MSB first.
  - Char 17: 8'h0d. Char 18: 8'h0a.
- Frame: start bit (0), 8 data bits LSB first, one stop bit (1).
  - Each bit is held on r_txd for exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE -> START on trigger.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START for the next char after CLKS_PER_BIT cycles, if char index < 18. There is no idle gap between characters.
  - STOP -> IDLE after the stop bit of char 18.
- Completion:
  - On the STOP -> IDLE edge: r_busy=0, r_txd=1, r_done=1 for exactly one cycle.
  - Total time from the trigger edge to the r_done assertion edge = 190*CLKS_PER_BIT cycles.
- Boundary conditions:
  - A halt rising edge while busy is ignored; no queueing.
  - w_halt held high produces one message only. A new message needs w_halt to go low, then high again, while IDLE.
  - Changes on w_rout/w_cnt after the capture edge do not affect the message.
  - Reset mid-message: on the reset edge, return to IDLE with r_txd=1, r_busy=0, r_done=0, and discard the partial frame.
  - Reset has priority over a trigger on the same edge.
  - r_done and a new trigger on the same cycle: the trigger is accepted only if it is a fresh rising edge, since the FSM is already IDLE on that cycle.
- Widths:
  - Bit-period counter is 16 bits, char index 5 bits, bit index 3 bits.
  - Nibble select: char i (0-7) uses result[31-4i:28-4i]; char i (9-16) uses count[31-4(i-9):28-4(i-9)].

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset, then w_halt 0->1 with w_rout=32'h05ffa000, w_cnt=32'h0000012c -> the bench UART decoder receives "05ffa000 0000012c\r\n" (19 bytes); r_txd=0 from the trigger edge; r_done pulses exactly 760 cycles after the trigger edge; r_busy is high for exactly those 760 cycles.
- w_halt held high for 2000 cycles after the first message -> exactly one message; r_txd stays 1 afterwards.
- Second w_halt pulse (low 2 cycles, then high) at cycle 300 of a message -> ignored; one message only. The same pulse pattern after r_done -> second message sent, carrying the new w_rout/w_cnt.
- w_rout changed to 32'hffffffff one cycle after trigger -> message still starts "05ffa000".
- w_rst asserted for one cycle at cycle 100 of a message -> next cycle r_txd=1, r_busy=0; no r_done; a later halt rising edge produces a complete, correct message.
- w_halt=1 throughout reset and after release -> no message. CLKS_PER_BIT=2 with w_rout=32'h0, w_cnt=32'hdeadbeef -> "00000000 deadbeef\r\n"; r_done pulses 380 cycles after trigger.
